// File: rtl/gpio_ctrl.sv
// gpio_ctrl -- register-mapped controller for the padframe GPIO bank.
//
// Sits between the design core and the pad cells. It drives the pad output,
// direction and pull-enable from bus registers. It synchronises and debounces
// the pad inputs, and latches debounced rising/falling edges into sticky W1C
// status registers. irq is the OR of the enabled status bits.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   req_valid/write/addr/wdata
//                         single-cycle bus request, always accepted
//   rsp_valid, rsp_rdata  registered read response, one cycle after a read
//   gpio_in               raw asynchronous pad inputs
//   gpio_out/dir/pullen   pad drive, direction (1=input), pull enable
//   irq                   level interrupt
//
// Register map (index = req_addr):
//   0 OUT rw | 1 DIR rw | 2 PULLEN rw | 3 IN ro | 4 RISE w1c | 5 FALL w1c
//   6 IRQ_EN rw | 7 reserved
// Bits at or above N_GPIO read as 0 and ignore writes.

// Per-bit input path: two-flop synchroniser, then a debounce counter.
// rise/fall pulse for one cycle in the cycle whose closing edge flips deb.
module gpio_deb #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic deb,
    output logic rise,
    output logic fall
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          upd;

    // s2 has disagreed with deb for DEB_CYCLES consecutive samples.
    assign upd  = (s2 != deb) && (cnt == CW'(DEB_CYCLES - 1));
    assign rise = upd &  s2;
    assign fall = upd & ~s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (upd) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module gpio_ctrl #(
    parameter int N_GPIO     = 25,
    parameter int DW         = 32,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_dir,
    output logic [N_GPIO-1:0] gpio_pullen,
    output logic              irq
);
    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_PULL = 3'd2;
    localparam logic [2:0] A_IN   = 3'd3;
    localparam logic [2:0] A_RISE = 3'd4;
    localparam logic [2:0] A_FALL = 3'd5;
    localparam logic [2:0] A_IEN  = 3'd6;

    logic [N_GPIO-1:0] r_out, r_dir, r_pull, r_rise, r_fall, r_ien;
    logic [N_GPIO-1:0] deb, rise_evt, fall_evt;
    logic [N_GPIO-1:0] wd, clr_rise, clr_fall;
    logic [DW-1:0]     rd_val;
    logic              wr, rd;

    // Per-lane synchroniser + debouncer
    for (genvar i = 0; i < N_GPIO; i++) begin : g_lane
        gpio_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (clk),
            .rst  (rst),
            .pin  (gpio_in[i]),
            .deb  (deb[i]),
            .rise (rise_evt[i]),
            .fall (fall_evt[i])
        );
    end

    // Write data bits above N_GPIO are architecturally ignored.
    if (DW > N_GPIO) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^req_wdata[DW-1:N_GPIO];
    end

    assign wr = req_valid &  req_write;
    assign rd = req_valid & ~req_write;
    assign wd = req_wdata[N_GPIO-1:0];

    assign clr_rise = (wr && req_addr == A_RISE) ? wd : '0;
    assign clr_fall = (wr && req_addr == A_FALL) ? wd : '0;

    always_comb begin
        rd_val = '0;
        case (req_addr)
            A_OUT:   rd_val = DW'(r_out);
            A_DIR:   rd_val = DW'(r_dir);
            A_PULL:  rd_val = DW'(r_pull);
            A_IN:    rd_val = DW'(deb);
            A_RISE:  rd_val = DW'(r_rise);
            A_FALL:  rd_val = DW'(r_fall);
            A_IEN:   rd_val = DW'(r_ien);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out     <= '0;
            r_dir     <= '1;
            r_pull    <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_ien     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (wr) begin
                case (req_addr)
                    A_OUT:   r_out  <= wd;
                    A_DIR:   r_dir  <= wd;
                    A_PULL:  r_pull <= wd;
                    A_IEN:   r_ien  <= wd;
                    default: ;
                endcase
            end
            // Set term is OR'd after the clear so a same-edge event wins.
            // Status only records edges on pins currently configured as inputs.
            r_rise <= (r_rise & ~clr_rise) | (rise_evt & r_dir);
            r_fall <= (r_fall & ~clr_fall) | (fall_evt & r_dir);

            rsp_valid <= rd;
            if (rd) rsp_rdata <= rd_val;
        end
    end

    assign gpio_out    = r_out;
    assign gpio_dir    = r_dir;
    assign gpio_pullen = r_pull;
    assign irq         = |((r_rise | r_fall) & r_ien);
endmodule
